// File: rtl/shape_processor_scheduler_if.sv
// Requester and processor bus bundle for shape_processor_scheduler.
// The master modport is the scheduler's view; slave is the environment (requesters + processor).
interface shape_processor_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_ctrl;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_error;
    logic                  write;
    logic [31:0]           write_data;
    logic                  read;
    logic [31:0]           read_data;
    logic                  error;

    modport master (
        input  req_valid, req_ctrl, read_data, error,
        output req_ready, rsp_valid, rsp_data, rsp_error, write, write_data, read
    );

    modport slave (
        output req_valid, req_ctrl, read_data, error,
        input  req_ready, rsp_valid, rsp_data, rsp_error, write, write_data, read
    );
endinterface

// File: rtl/shape_processor_scheduler.sv
// Round-robin scheduler sharing one shape_processor between NUM_REQ requesters.
// Optional feature: SHAPE_SCHED_SKIP_REDUNDANT_EN skips re-writing the last accepted CTRL word.
module shape_processor_scheduler #(
    parameter int NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shape_processor_scheduler_if.master   bus,
    output logic                          busy
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_CHECK = 3'd2,
        S_READ  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gnt_q, gnt_d;
    logic [31:0]          cmd_q, cmd_d;
    logic [31:0]          res_q, res_d;
    logic                 err_q, err_d;
    logic                 arm_q;
    logic [PW-1:0]        win_s;
    logic                 any_s;
    logic [31:0]          win_ctrl_s;
    logic                 skip_s;
    logic                 accept_s;
    logic [NUM_REQ-1:0]   req_ready_s;

    logic                 write_q, write_d;
    logic                 read_q, read_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 busy_q, busy_d;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PW-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Round-robin winner: scan from ptr downwards so the lowest offset wins
    always_comb begin
        int idx;
        win_s = '0;
        any_s = 1'b0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                win_s = PW'(idx);
                any_s = 1'b1;
            end else begin
                win_s = win_s;
            end
        end
    end

    assign win_ctrl_s = bus.req_ctrl[int'(win_s)*32 +: 32];
    assign accept_s   = (state_q == S_IDLE) && arm_q && any_s;

`ifdef SHAPE_SCHED_SKIP_REDUNDANT_EN
    logic [31:0] last_q;
    logic        last_vld_q;

    assign skip_s = last_vld_q && (win_ctrl_s == last_q);

    // Tracks the last word the processor accepted without error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 32'd0;
            last_vld_q <= 1'b0;
        end else if ((state_q == S_CHECK) && !bus.error) begin
            last_q     <= cmd_q;
            last_vld_q <= 1'b1;
        end else begin
            last_q     <= last_q;
            last_vld_q <= last_vld_q;
        end
    end
`else
    assign skip_s = 1'b0;
`endif

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cmd_q   <= 32'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
            err_q   <= err_d;
            arm_q   <= 1'b1;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cmd_d   = cmd_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    gnt_d   = win_s;
                    cmd_d   = win_ctrl_s;
                    err_d   = 1'b0;
                    ptr_d   = (win_s == PW'(NUM_REQ - 1)) ? '0 : win_s + PW'(1);
                    state_d = skip_s ? S_READ : S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.error) begin
                    err_d   = 1'b1;
                    res_d   = 32'd0;
                    state_d = S_RESP;
                end else begin
                    err_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                res_d   = bus.read_data;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every strobe leaves a flop
    always_comb begin
        write_d     = 1'b0;
        read_d      = 1'b0;
        rsp_valid_d = '0;
        rsp_data_d  = 32'd0;
        rsp_error_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_WRITE: write_d = 1'b1;
            S_READ:  read_d  = 1'b1;
            S_RESP: begin
                rsp_valid_d = to_onehot(gnt_d);
                rsp_data_d  = res_d;
                rsp_error_d = err_d;
            end
            default: write_d = 1'b0;
        endcase
    end

    // Registered output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 32'd0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            write_q     <= write_d;
            read_q      <= read_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            busy_q      <= busy_d;
        end
    end

    // Accept must answer in the same cycle as the request, so it stays combinational
    always_comb begin
        if (accept_s) begin
            req_ready_s = to_onehot(win_s);
        end else begin
            req_ready_s = '0;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_error  = rsp_error_q;
    assign bus.write      = write_q;
    assign bus.write_data = cmd_q;
    assign bus.read       = read_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_shape_processor_scheduler.sv
// Scoreboard bench for shape_processor_scheduler with a behavioural processor and arbitration model.
module tb_shape_processor_scheduler;
    localparam int N = 3;
`ifdef SHAPE_SCHED_SKIP_REDUNDANT_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    shape_processor_scheduler_if #(.NUM_REQ(N)) bus();

    shape_processor_scheduler #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] oh;
        logic [31:0]  data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t        sbq[$];
    int          grant_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ptr_m = 0;
    logic [31:0] last_m = 32'd0;
    logic        last_vld_m = 1'b0;
    logic        infl = 1'b0;
    logic [31:0] infl_cmd = 32'd0;
    logic        infl_skip = 1'b0;
    logic        infl_err = 1'b0;
    int          infl_t = 0;
    logic [N-1:0] acc_seen = '0;
    int          err_mode = 0;
    logic [31:0] proc_reg = 32'd0;
    int          err_cnt = 0;
    int          n_writes = 0;

    // Processor result function
    function automatic logic [31:0] pf(input logic [31:0] x);
        return x * 32'd5 + 32'd10;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_write"}, 32'(bus.write), 32'd0);
        chk({tag, "_write_data"}, bus.write_data, 32'd0);
        chk({tag, "_read"}, 32'(bus.read), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor + processor model + scoreboard
    initial begin
        logic ov;
        int   g;
        int   gi;
        logic [31:0] ctrl;
        logic skip;
        logic err;
        exp_t e;
        bus.error     = 1'b0;
        bus.read_data = pf(32'd0);
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ov = infl;
                if (err_cnt > 0) begin
                    err_cnt--;
                    if (err_cnt == 0) bus.error = 1'b0;
                end
                if (bus.write || bus.read) chk("wr_rd_exclusive", 32'(bus.write & bus.read), 32'd0);
                if (bus.write) begin
                    n_writes++;
                    chk("write_expected", {30'd0, infl, infl_skip}, 32'd2);
                    chk("write_cycle", 32'(cyc), 32'(infl_t + 1));
                    chk("write_data", bus.write_data, infl_cmd);
                    bus.error = infl_err;
                    err_cnt   = 2;
                    if (!infl_err) begin
                        proc_reg      = bus.write_data;
                        bus.read_data = pf(proc_reg);
                    end
                end
                if (bus.read) begin
                    chk("read_cycle", 32'(cyc), 32'(infl_t + (infl_skip ? 1 : 3)));
                    chk("read_on_error", 32'(infl_err), 32'd0);
                end
                if (bus.rsp_valid != '0) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_target", 32'(bus.rsp_valid), 32'(e.oh));
                        chk("rsp_data", bus.rsp_data, e.data);
                        chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
                        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                        infl = 1'b0;
                    end
                end
                if (bus.req_ready != '0) begin
                    gi = -1;
                    for (int i = 0; i < N; i++) if (bus.req_ready[i]) gi = i;
                    grant_log.push_back(gi);
                    chk("accept_overlap", 32'(ov), 32'd0);
                    g = rr_pick(bus.req_valid, ptr_m);
                    if (g < 0) begin
                        chk("grant_no_request", 32'(bus.req_ready), 32'd0);
                    end else begin
                        chk("grant", 32'(bus.req_ready), 32'(1) << g);
                        ctrl = bus.req_ctrl[32*g +: 32];
                        skip = SKIP_EN && last_vld_m && (ctrl == last_m);
                        err  = skip ? 1'b0 :
                               (err_mode == 2) ? ($urandom_range(0, 3) == 0) : (err_mode == 1);
                        if (!skip && !err) begin
                            last_m     = ctrl;
                            last_vld_m = 1'b1;
                        end
                        e.oh   = N'(1) << g;
                        e.err  = err;
                        e.data = err ? 32'd0 : pf(ctrl);
                        e.cyc  = cyc + (skip ? 2 : (err ? 3 : 4));
                        sbq.push_back(e);
                        infl      = 1'b1;
                        infl_cmd  = ctrl;
                        infl_skip = skip;
                        infl_err  = err;
                        infl_t    = cyc;
                        ptr_m     = (g + 1) % N;
                        acc_seen[g] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (!busy && sbq.size() == 0 && !infl && bus.req_valid == '0) break;
        end
        chk("idle_timeout", {29'd0, busy, sbq.size() != 0, infl}, 32'd0);
    endtask

    task automatic send(input int i, input logic [31:0] ctrl, input int mode);
        err_mode    = mode;
        acc_seen[i] = 1'b0;
        bus.req_ctrl[32*i +: 32] = ctrl;
        bus.req_valid[i] = 1'b1;
        for (int k = 0; k < 50 && !acc_seen[i]; k++) begin
            @(posedge clk);
            #2;
        end
        chk("accept_timeout", 32'(acc_seen[i]), 32'd1);
        bus.req_valid[i] = 1'b0;
        acc_seen[i] = 1'b0;
        wait_idle();
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && bus.req_valid != '0; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin
                    acc_seen[i] = 1'b0;
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        chk("drain_timeout", 32'(bus.req_valid), 32'd0);
        wait_idle();
    endtask

    task automatic run_rand(input int ncmd);
        int target;
        target   = grant_log.size() + ncmd;
        err_mode = 2;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin
                    acc_seen[i] = 1'b0;
                    bus.req_valid[i] = 1'b0;
                end else if (!bus.req_valid[i] && grant_log.size() < target &&
                             $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       bus.req_ctrl[32*i +: 32] = 32'h0000_00A5;
                        1:       bus.req_ctrl[32*i +: 32] = 32'h0000_0012;
                        2:       bus.req_ctrl[32*i +: 32] = 32'($urandom_range(0, 7));
                        default: bus.req_ctrl[32*i +: 32] = $urandom;
                    endcase
                    bus.req_valid[i] = 1'b1;
                end
            end
            if (grant_log.size() >= target) break;
        end
        chk("rand_progress", 32'(grant_log.size() >= target), 32'd1);
        drain();
    endtask

    // Stimulus sequence
    initial begin
        int base;
        int w0;
        int found;
        bus.req_valid = '0;
        bus.req_ctrl  = '0;
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("post_reset");

        // Fairness with every requester permanently valid
        err_mode = 0;
        for (int i = 0; i < N; i++) bus.req_ctrl[32*i +: 32] = 32'h100 * (i + 1);
        base = grant_log.size();
        bus.req_valid = '1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            acc_seen = '0;
            if (grant_log.size() - base >= 6) break;
        end
        bus.req_valid = '0;
        acc_seen = '0;
        chk("fair_count", 32'(grant_log.size() - base), 32'd6);
        for (int k = 0; k < 6 && base + k < grant_log.size(); k++)
            chk("fair_order", 32'(grant_log[base + k]), 32'(k % N));
        wait_idle();

        send(0, 32'h0000_0012, 0);
        send(2, 32'h0000_0077, 1);

        w0 = n_writes;
        send(0, 32'h0000_00A5, 0);
        send(1, 32'h0000_00A5, 0);
        chk("repeat_writes", 32'(n_writes - w0), SKIP_EN ? 32'd1 : 32'd2);
        w0 = n_writes;
        send(2, 32'h0000_0033, 1);
        send(0, 32'h0000_00A5, 0);
        chk("after_reject_writes", 32'(n_writes - w0), SKIP_EN ? 32'd1 : 32'd2);

        run_rand(200);

        // Reset while the processor read is in progress
        err_mode = 0;
        acc_seen = '0;
        bus.req_ctrl[32*1 +: 32] = 32'h5A5A_0001;
        bus.req_valid[1] = 1'b1;
        for (int k = 0; k < 50 && !acc_seen[1]; k++) begin
            @(posedge clk);
            #2;
        end
        bus.req_valid[1] = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.read) begin
                found = 1;
                break;
            end
        end
        chk("reach_read", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        infl = 1'b0;
        ptr_m = 0;
        last_vld_m = 1'b0;
        acc_seen = '0;
        err_cnt = 0;
        bus.error = 1'b0;
        bus.req_ctrl[32*1 +: 32] = 32'h0BAD_0001;
        bus.req_ctrl[32*2 +: 32] = 32'h0BAD_0002;
        bus.req_valid = 3'b110;
        #1;
        check_zero("reset_mid");
        base = grant_log.size();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("busy_after_reset", 32'(busy), 32'd0);
        drain();
        chk("post_reset_grants", 32'(grant_log.size() - base), 32'd2);
        if (grant_log.size() - base >= 2) begin
            chk("post_reset_first", 32'(grant_log[base]), 32'd1);
            chk("post_reset_second", 32'(grant_log[base + 1]), 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shape_processor_scheduler.md
# shape_processor_scheduler

Round-robin command scheduler that shares one `shape_processor` between `NUM_REQ` requesters. Each requester hands over a 32-bit CTRL SFR write word. The scheduler writes it through the processor's write bus, checks `error`, reads the result through the read bus and returns result and status to the granted requester. It is the sole master of the processor's `write`/`read` ports.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `clk` input 1: clock; all logic on posedge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input NUM_REQ: requester i has a command pending; held until accepted.
- `req_ctrl` input NUM_REQ*32: command word of requester i at bits [32*i+31:32*i]; stable while `req_valid[i]`.
- `req_ready` output NUM_REQ: one-cycle accept pulse, one-hot or zero.
- `rsp_valid` output NUM_REQ: one-cycle response pulse to the granted requester, one-hot or zero.
- `rsp_data` output 32: result; valid only when any `rsp_valid` is high.
- `rsp_error` output 1: command rejected by the processor; qualifies `rsp_valid`.
- `busy` output 1: FSM not in IDLE.
- `write` output 1: processor write strobe.
- `write_data` output 32: processor write data.
- `read` output 1: processor read strobe.
- `read_data` input 32: processor read data.
- `error` input 1: processor error flag.

## Operation
- FSM states: IDLE, WRITE, CHECK, READ, RESP.
- IDLE: when any `req_valid` is high, grant the round-robin winner g. Pulse `req_ready[g]`, latch `req_ctrl[g]` into `cmd_q`, store g, then go to WRITE. With no valid request, stay in IDLE.
- WRITE: `write`=1, `write_data`=`cmd_q`, then go to CHECK.
- CHECK: sample `error`.
  - `error`=1: `err_q`=1, `res_q`=0, go to RESP.
  - `error`=0: `err_q`=0, go to READ.
- READ: `read`=1; `res_q` <= `read_data` on this edge; go to RESP.
- RESP: `rsp_valid[g]`=1, `rsp_data`=`res_q`, `rsp_error`=`err_q`, then go to IDLE.
- Round-robin arbitration:
  - Priority pointer `ptr` starts at 0 after reset.
  - The winner is the first valid requester scanning ptr, ptr+1, … modulo NUM_REQ.
  - After a grant, `ptr` = (g+1) mod NUM_REQ.
- A request that deasserts before it is accepted is simply not granted. Requesters must not drop `req_valid` before `req_ready`.
- `write_data` outputs `cmd_q` at all times; it is 0 after reset until the first grant.
- Reset (asynchronous, at any state, including mid-command): FSM to IDLE; `ptr`, `cmd_q`, `res_q`, `err_q` and the last-written tracker are cleared. The in-flight command is dropped and no response is issued.
- Reset values of outputs: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0, `busy`=0, `write`=0, `write_data`=0, `read`=0.

## Timing
- Accept in cycle T (IDLE), `write` in T+1, `error` sampled in T+2, `read` in T+3, `rsp_valid` in T+4.
- Error path: accept T, `rsp_valid` in T+3.
- The next accept happens no earlier than the cycle after RESP, so there is at most one command in flight.
- `write` and `read` are never high in the same cycle. Each is high for exactly one cycle per command.
- Simultaneous `req_valid` on all inputs: grants rotate strictly, so with N always-valid requesters each one is served once every N commands.

## Configuration
- `SHAPE_SCHED_SKIP_REDUNDANT_EN` defined:
  - The scheduler tracks the last word written with `error`=0 (`last_q`, `last_vld`). `last_vld` is cleared on reset.
  - If `last_vld` is high and the newly accepted `cmd_q` equals `last_q`, the FSM goes IDLE -> READ directly, with no `write` pulse and `rsp_error`=0. Latency is accept T, `read` T+1, `rsp_valid` T+2.
  - Rejected writes leave `last_q` unchanged.
- Undefined: every command takes the full WRITE/CHECK path. No tracker registers exist.

## Test plan
- Single command: requester 0 sends 0x0000_0012, processor `error`=0, `read_data`=0x0000_0064. Required: `write` in T+1 with `write_data`=0x12, `read` in T+3, then `rsp_valid`=2'b01, `rsp_data`=0x64, `rsp_error`=0 in T+4.
- Error path: processor raises `error` in the cycle after `write`. Required: no `read` pulse, `rsp_valid` in T+3 with `rsp_error`=1 and `rsp_data`=0.
- Fairness: NUM_REQ=3, all `req_valid` held high for 6 commands. Required: grant order 0,1,2,0,1,2 and each `rsp_valid` goes to the matching requester.
- Reset mid-command: assert `rst_n`=0 while in READ. Required: all outputs read 0 immediately. After release, `busy`=0, and a pending requester 1 is granted with priority starting at 0.
- With `SHAPE_SCHED_SKIP_REDUNDANT_EN`: send 0xA5 twice with no error. Required: one `write` pulse total, and the second command responds in T+2.
- With `SHAPE_SCHED_SKIP_REDUNDANT_EN`: send 0xA5, then 0xA5 rejected path is not possible; instead send 0xA5, then 0x33 with `error`, then 0xA5 again. Required: the third command is skipped (no `write`), because `last_q` remains 0xA5.
